// File: rtl/lane_collector_16_pkg.sv
// Shared constants and state encoding for the 16-lane collector.
// Imported by the round-robin picker and the collector top.
package lane_collector_16_pkg;

  localparam int LANES = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/lane_collector_16_rr_pick.sv
// Combinational round-robin search: first set req bit at or above
// ptr, wrapping from lane 15 back to lane 0.
module rr_pick_16
  import lane_collector_16_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] grant
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = ptr + SEL_W'(i);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/lane_collector_16.sv
// Collects words from 16 request lanes into a single-entry output
// register, granting lanes round-robin with same-cycle drain/refill.
module lane_collector_16
  import lane_collector_16_pkg::*;
#(
  parameter int nrOfBits = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [nrOfBits-1:0] muxIn_0,
  input  logic [nrOfBits-1:0] muxIn_1,
  input  logic [nrOfBits-1:0] muxIn_2,
  input  logic [nrOfBits-1:0] muxIn_3,
  input  logic [nrOfBits-1:0] muxIn_4,
  input  logic [nrOfBits-1:0] muxIn_5,
  input  logic [nrOfBits-1:0] muxIn_6,
  input  logic [nrOfBits-1:0] muxIn_7,
  input  logic [nrOfBits-1:0] muxIn_8,
  input  logic [nrOfBits-1:0] muxIn_9,
  input  logic [nrOfBits-1:0] muxIn_10,
  input  logic [nrOfBits-1:0] muxIn_11,
  input  logic [nrOfBits-1:0] muxIn_12,
  input  logic [nrOfBits-1:0] muxIn_13,
  input  logic [nrOfBits-1:0] muxIn_14,
  input  logic [nrOfBits-1:0] muxIn_15,
  input  logic [LANES-1:0]    req,
  input  logic                enable,
  output logic [LANES-1:0]    ack,
  input  logic                outReady,
  output logic [nrOfBits-1:0] muxOut,
  output logic [SEL_W-1:0]    outSel,
  output logic                outValid
);

  logic [nrOfBits-1:0] lane_data [LANES];

  assign lane_data[0]  = muxIn_0;
  assign lane_data[1]  = muxIn_1;
  assign lane_data[2]  = muxIn_2;
  assign lane_data[3]  = muxIn_3;
  assign lane_data[4]  = muxIn_4;
  assign lane_data[5]  = muxIn_5;
  assign lane_data[6]  = muxIn_6;
  assign lane_data[7]  = muxIn_7;
  assign lane_data[8]  = muxIn_8;
  assign lane_data[9]  = muxIn_9;
  assign lane_data[10] = muxIn_10;
  assign lane_data[11] = muxIn_11;
  assign lane_data[12] = muxIn_12;
  assign lane_data[13] = muxIn_13;
  assign lane_data[14] = muxIn_14;
  assign lane_data[15] = muxIn_15;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [nrOfBits-1:0] data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             slot_free;
  logic             capture;

  rr_pick_16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .any   (pick_any),
    .grant (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    ack       = '0;
    slot_free = (state_q == EMPTY) || outReady;
    // reset gate keeps ack quiet while the flops are held
    capture   = slot_free && enable && pick_any && !reset;
    if (capture) begin
      ack[pick_idx] = 1'b1;
      data_d        = lane_data[pick_idx];
      sel_d         = pick_idx;
      ptr_d         = pick_idx + SEL_W'(1);
    end
    unique case (state_q)
      EMPTY: if (capture) state_d = FULL;
      FULL:  if (outReady && !capture) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign muxOut   = data_q;
  assign outSel   = sel_q;
  assign outValid = (state_q == FULL);

endmodule
